veda: RTL and testbench

VEDA -- requirements
Module: veda

---
 rtl/veda.sv | 84 ++++++++
 tb/tb_veda.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/veda.sv
`default_nettype none
//============================================================================
// Module   : veda
// Purpose  : Small register-file memory with a registered read port and two
//            addressing modes.
//              mode 0 (direct)       : optional write of a to mem[b], read of
//                                      mem[c] into out (read-before-write).
//              mode 1 (indexed load) : read of mem[b + c] into out; the
//                                      memory is never written in this mode.
//            Addresses use only the low log2(DEPTH) bits (wrap-around).
//            A synchronous reset clears every word and the output register.
// Ports    : clk   - clock, rising edge active
//            reset - synchronous, active-high reset
//            a     - write data             [WIDTH-1:0]
//            out   - registered read data   [WIDTH-1:0]
//            mode  - 0 = direct, 1 = indexed load
//            b     - write address / base   [LEN-1:0]
//            c     - read address / offset  [LEN-1:0]
//            write - write enable (mode 0 only)
// Revision : 1.0 - initial release
//============================================================================
module veda #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int LEN   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] out,
    input  logic             mode,
    input  logic [LEN-1:0]   b,
    input  logic [LEN-1:0]   c,
    input  logic             write
);

    localparam int c_aw = $clog2(DEPTH);

    // Storage lives in flops so that reset can clear every word in one edge.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_out;

    logic [LEN-1:0]   w_sum;
    logic [c_aw-1:0]  w_wr_addr;
    logic [c_aw-1:0]  w_rd_addr;
    logic             w_we;

    // Base + offset as an unsigned LEN-bit sum; the carry out is dropped by
    // the assignment width, and the upper bits are dropped by the slice below.
    assign w_sum     = b + c;
    assign w_wr_addr = b[c_aw-1:0];
    assign w_rd_addr = mode ? w_sum[c_aw-1:0] : c[c_aw-1:0];
    assign w_we      = write & ~mode;

    // Address bits above the index width are intentionally ignored.
    logic w_unused;
    assign w_unused = ^{w_sum, b, c};

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_mem[gi] <= '0;
                end else if (w_we && (w_wr_addr == c_aw'(gi))) begin
                    r_mem[gi] <= a;
                end
            end
        end
    endgenerate

    // The read samples the array value from before this edge's write, which
    // gives read-before-write behaviour when the addresses collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
        end else begin
            r_out <= r_mem[w_rd_addr];
        end
    end

    assign out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_veda.sv
`default_nettype none
//============================================================================
// Module   : tb_veda
// Purpose  : Directed self-checking bench for veda (default parameters).
// Revision : 1.0 - initial release
//============================================================================
module tb_veda;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] out;
    logic        mode;
    logic [31:0] b;
    logic [31:0] c;
    logic        write;

    int vectors;
    int miscompares;

    veda #(
        .WIDTH (32),
        .DEPTH (32),
        .LEN   (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .out   (out),
        .mode  (mode),
        .b     (b),
        .c     (c),
        .write (write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one operation across a rising edge, then sample 1 time unit later.
    task automatic step(input logic m, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] cv, input logic w);
        mode  = m;
        a     = av;
        b     = bv;
        c     = cv;
        write = w;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] expected);
        vectors++;
        assert (out === expected) else begin
            miscompares++;
            $error("FAIL %s: out=%0d expected %0d", tag, out, expected);
        end
    endtask

    // Hand-derived memory contents after the REQ-027..029 vectors.
    function automatic logic [31:0] exp_after_first(input int idx);
        case (idx)
            10:      return 32'd144;
            11:      return 32'd170;
            13:      return 32'd134;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        mode  = 1'b0;
        a     = '0;
        b     = '0;
        c     = '0;
        write = 1'b0;
        #2;

        // Reset pulse; also drive a write during reset to show it is ignored.
        step(1'b0, 32'd99, 32'd5, 32'd5, 1'b1);
        step(1'b0, 32'd99, 32'd5, 32'd5, 1'b1);
        check("reset_out", 32'd0);
        reset = 1'b0;

        step(1'b0, 32'd134, 32'd13, 32'd13, 1'b1);
        check("rbw_13_old", 32'd0);
        step(1'b0, 32'd144, 32'd10, 32'd10, 1'b1);
        check("rbw_10_old", 32'd0);
        step(1'b0, 32'd170, 32'd11, 32'd10, 1'b1);
        check("read_10", 32'd144);
        step(1'b1, 32'd200, 32'd10, 32'd3, 1'b1);
        check("idx_ea13", 32'd134);

        // Full scan: mode-1 write must not have stored 200 anywhere.
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 32'd0, 32'd0, 32'(i), 1'b0);
            check($sformatf("scan_%0d", i), exp_after_first(i));
        end

        step(1'b0, 32'd210, 32'd13, 32'd13, 1'b1);
        check("rbw2_old", 32'd134);
        step(1'b0, 32'd201, 32'd13, 32'd13, 1'b1);
        check("rbw2_new", 32'd210);

        // Wrap-around on write address, then indexed read with wrap.
        step(1'b0, 32'd7, 32'd33, 32'd0, 1'b1);
        check("wrap_wr_rd0", 32'd0);
        step(1'b1, 32'd0, 32'd31, 32'd2, 1'b0);
        check("idx_wrap_31_2", 32'd7);
        step(1'b1, 32'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("idx_carry_drop", 32'd7);
        step(1'b0, 32'd0, 32'd0, 32'd45, 1'b0);
        check("rd_wrap_45", 32'd201);

        // write=0 leaves memory untouched.
        step(1'b0, 32'd99, 32'd10, 32'd10, 1'b0);
        check("nowr_rd10", 32'd144);
        step(1'b0, 32'd0, 32'd0, 32'd10, 1'b0);
        check("nowr_keep10", 32'd144);

        // Mid-sequence reset with a pending write.
        reset = 1'b1;
        step(1'b0, 32'd55, 32'd20, 32'd13, 1'b1);
        check("midreset_out", 32'd0);
        reset = 1'b0;
        step(1'b0, 32'd0, 32'd0, 32'd13, 1'b0);
        check("post_reset_13", 32'd0);
        step(1'b0, 32'd0, 32'd0, 32'd20, 1'b0);
        check("post_reset_20", 32'd0);
        step(1'b1, 32'd0, 32'd0, 32'd1, 1'b0);
        check("post_reset_1", 32'd0);

        // out holds between edges.
        #4;
        check("hold", 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
